gmii_frame_gen: RTL and testbench

//  Synthesizable, parametrised GMII stimulus generator and loopback checker for the PCS 1000BASE-X bench.
//  - TX side: drives TXD/TX_EN with a programmable burst of frames.
//  - RX side: checks RXD/RX_DV returned by the receiver against the same payload sequence.

---
 rtl/gmii_frame_gen_pkg.sv | 30 +++
 rtl/gmii_payload_gen.sv | 44 ++++
 rtl/gmii_frame_gen.sv | 213 +++++++++++++++++++++
 tb/tb_gmii_frame_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_frame_gen_pkg.sv
// Shared constants, encodings and the LFSR step used by the GMII frame generator and its checker.
package gmii_frame_gen_pkg;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam int         PRE_LEN  = 8;

  // x^8 + x^6 + x^5 + x^4 + 1, taps on bits 7, 5, 4, 3 of a left-shifting register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_CONST = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_IPG,
    ST_DONE
  } tx_state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gmii_payload_gen.sv
// Payload byte generator shared by the TX path and the RX checker; data is the byte for this cycle.
module gmii_payload_gen
  import gmii_frame_gen_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              restart,
  input  logic              advance,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] value;
  logic [DATA_W-1:0] seed_eff;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] nxt;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    seed_eff = seed;
    if (mode_e'(mode) == MODE_LFSR && seed == '0) seed_eff = DATA_W'(1);
    // A restart presents the seed in the same cycle so the first byte needs no extra latency.
    cur = restart ? seed_eff : value;
    nxt = cur;
    case (mode_e'(mode))
      MODE_CONST: nxt = cur;
      MODE_LFSR:  nxt[7:0] = lfsr_next(cur[7:0]);
      default:    nxt = cur + DATA_W'(1);
    endcase
  end

  assign data = cur;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset)       value <= '0;
    else if (advance) value <= nxt;
    else if (restart) value <= cur;
  end

endmodule

// File: rtl/gmii_frame_gen.sv
// GMII burst generator (preamble, payload, IPG) with a loopback checker that counts frames and errors.
module gmii_frame_gen
  import gmii_frame_gen_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 11,
  parameter int CNT_W       = 16,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_frames,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [7:0]        ipg_len,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] TXD,
  output logic              TX_EN,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  tx_frames,
  input  logic [DATA_W-1:0] RXD,
  input  logic              RX_DV,
  output logic [CNT_W-1:0]  rx_frames,
  output logic [CNT_W-1:0]  rx_errors
);

  localparam logic [LEN_W-1:0] PRE_LAST = LEN_W'(PRE_LEN - 1);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, v} + (CNT_W+1)'(n);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  tx_state_e         state;
  logic [LEN_W-1:0]  cfg_len;
  logic [7:0]        cfg_ipg;
  logic [1:0]        cfg_mode;
  logic [DATA_W-1:0] cfg_seed;
  logic [CNT_W-1:0]  frames_left;
  logic [LEN_W-1:0]  cnt;

  logic              accept;
  logic [LEN_W-1:0]  len_eff;
  logic [LEN_W-1:0]  len_last;
  logic [LEN_W-1:0]  ipg_last;
  logic              tx_restart;
  logic              tx_advance;
  logic [DATA_W-1:0] tx_byte;

  assign accept   = (state == ST_IDLE) && start;
  assign len_eff  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign len_last = len_eff - LEN_W'(1);
  assign ipg_last = (cfg_ipg == '0) ? '0 : LEN_W'(cfg_ipg) - LEN_W'(1);

  always_comb begin
    tx_restart = 1'b0;
    tx_advance = 1'b0;
    case (state)
      ST_IDLE: tx_restart = accept && !PREAMBLE_EN && (num_frames != '0);
      ST_PRE:  tx_restart = (cnt == PRE_LAST);
      ST_DATA: tx_advance = (cnt != len_last);
      ST_IPG:  tx_restart = !PREAMBLE_EN && (cnt == ipg_last) && (frames_left != '0);
      default: ;
    endcase
    if (tx_restart) tx_advance = 1'b1;
  end

  // In IDLE the config registers are not loaded yet, so the first byte comes from the live inputs.
  gmii_payload_gen #(.DATA_W(DATA_W)) u_tx_gen (
    .clock   (clock),
    .reset   (reset),
    .mode    ((state == ST_IDLE) ? mode : cfg_mode),
    .seed    ((state == ST_IDLE) ? seed : cfg_seed),
    .restart (tx_restart),
    .advance (tx_advance),
    .data    (tx_byte)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      TXD         <= '0;
      TX_EN       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_frames   <= '0;
      frames_left <= '0;
      cnt         <= '0;
      cfg_len     <= '0;
      cfg_ipg     <= '0;
      cfg_mode    <= '0;
      cfg_seed    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          cfg_len     <= frame_len;
          cfg_ipg     <= ipg_len;
          cfg_mode    <= mode;
          cfg_seed    <= seed;
          busy        <= 1'b1;
          tx_frames   <= '0;
          frames_left <= num_frames;
          cnt         <= '0;
          if (num_frames == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            TX_EN <= 1'b1;
            state <= PREAMBLE_EN ? ST_PRE : ST_DATA;
            TXD   <= PREAMBLE_EN ? DATA_W'(PRE_BYTE) : tx_byte;
          end
        end
        ST_PRE: if (cnt == PRE_LAST) begin
          state <= ST_DATA;
          TXD   <= tx_byte;
          cnt   <= '0;
        end else begin
          TXD <= (cnt == PRE_LAST - LEN_W'(1)) ? DATA_W'(SFD_BYTE) : DATA_W'(PRE_BYTE);
          cnt <= cnt + LEN_W'(1);
        end
        ST_DATA: if (cnt == len_last) begin
          state       <= ST_IPG;
          TX_EN       <= 1'b0;
          TXD         <= '0;
          cnt         <= '0;
          tx_frames   <= sat_add(tx_frames, 2'd1);
          frames_left <= frames_left - CNT_W'(1);
        end else begin
          TXD <= tx_byte;
          cnt <= cnt + LEN_W'(1);
        end
        ST_IPG: if (cnt == ipg_last) begin
          cnt <= '0;
          if (frames_left == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            TX_EN <= 1'b1;
            state <= PREAMBLE_EN ? ST_PRE : ST_DATA;
            TXD   <= PREAMBLE_EN ? DATA_W'(PRE_BYTE) : tx_byte;
          end
        end else begin
          cnt <= cnt + LEN_W'(1);
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Checker: skips the preamble, compares payload bytes, and checks length on RX_DV fall.
  logic             dv_q;
  logic [3:0]       skip;
  logic [LEN_W:0]   rx_len;
  logic             rise;
  logic             fall;
  logic             is_skip;
  logic             payload;
  logic             byte_err;
  logic             len_err;
  logic [DATA_W-1:0] chk_byte;

  assign rise     = RX_DV && !dv_q;
  assign fall     = !RX_DV && dv_q;
  assign is_skip  = rise ? PREAMBLE_EN : (skip != '0);
  assign payload  = RX_DV && !is_skip;
  assign byte_err = payload && (RXD != chk_byte);
  assign len_err  = fall && (rx_len != {1'b0, len_eff});

  gmii_payload_gen #(.DATA_W(DATA_W)) u_chk_gen (
    .clock   (clock),
    .reset   (reset),
    .mode    (cfg_mode),
    .seed    (cfg_seed),
    .restart (rise),
    .advance (payload),
    .data    (chk_byte)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      dv_q      <= 1'b0;
      skip      <= '0;
      rx_len    <= '0;
      rx_frames <= '0;
      rx_errors <= '0;
    end else begin
      dv_q <= RX_DV;
      if (RX_DV && is_skip) skip <= rise ? 4'(PRE_LEN - 1) : skip - 4'd1;
      if (payload) begin
        if (rise)            rx_len <= (LEN_W+1)'(1);
        else if (rx_len != '1) rx_len <= rx_len + (LEN_W+1)'(1);
      end else if (rise) begin
        rx_len <= '0;
      end
      if (accept) begin
        rx_frames <= '0;
        rx_errors <= '0;
      end else begin
        if (fall) rx_frames <= sat_add(rx_frames, 2'd1);
        if (byte_err || len_err)
          rx_errors <= sat_add(rx_errors, {1'b0, byte_err} + {1'b0, len_err});
      end
    end
  end

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Bench for gmii_frame_gen: two instances (no preamble / preamble) with a TXD->RXD loopback path.
module tb_gmii_frame_gen;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 11;
  localparam int CNT_W  = 16;

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       dn;
    logic       bz;
  } step_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              start [2];
  logic [CNT_W-1:0]  num_frames;
  logic [LEN_W-1:0]  frame_len;
  logic [7:0]        ipg_len;
  logic [1:0]        mode;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] txd [2];
  logic              tx_en [2];
  logic              busy [2];
  logic              done [2];
  logic [CNT_W-1:0]  tx_frames [2];
  logic [CNT_W-1:0]  rx_frames [2];
  logic [CNT_W-1:0]  rx_errors [2];
  logic [DATA_W-1:0] rxd [2];
  logic              rx_dv [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  gmii_frame_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .PREAMBLE_EN(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start[0]), .num_frames(num_frames),
    .frame_len(frame_len), .ipg_len(ipg_len), .mode(mode), .seed(seed),
    .TXD(txd[0]), .TX_EN(tx_en[0]), .busy(busy[0]), .done(done[0]), .tx_frames(tx_frames[0]),
    .RXD(rxd[0]), .RX_DV(rx_dv[0]), .rx_frames(rx_frames[0]), .rx_errors(rx_errors[0])
  );

  gmii_frame_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .PREAMBLE_EN(1'b1)) dut1 (
    .clock(clock), .reset(reset), .start(start[1]), .num_frames(num_frames),
    .frame_len(frame_len), .ipg_len(ipg_len), .mode(mode), .seed(seed),
    .TXD(txd[1]), .TX_EN(tx_en[1]), .busy(busy[1]), .done(done[1]), .tx_frames(tx_frames[1]),
    .RXD(rxd[1]), .RX_DV(rx_dv[1]), .rx_frames(rx_frames[1]), .rx_errors(rx_errors[1])
  );

  // Loopback with one cycle of delay; fault injection (bit flip, truncation) applies to dut0 only.
  int burst_id = 0;
  int seen_id = 0;
  int lb_frame [2] = '{0, 0};
  int lb_idx [2] = '{0, 0};
  int lb_total [2] = '{0, 0};
  int flip_frame = -1;
  int flip_idx = 0;
  int trunc_frame = -1;
  logic [DATA_W-1:0] flip_mask = 8'h10;
  logic [DATA_W-1:0] lb_v;
  logic              lb_keep;

  initial begin
    rxd   = '{8'h00, 8'h00};
    rx_dv = '{1'b0, 1'b0};
  end

  always @(negedge clock) begin
    if (seen_id != burst_id) begin
      seen_id  = burst_id;
      lb_frame = '{0, 0};
      lb_idx   = '{0, 0};
    end
    for (int d = 0; d < 2; d++) begin
      if (tx_en[d] === 1'b1) begin
        lb_v    = txd[d];
        lb_keep = 1'b1;
        if (d == 0 && lb_frame[d] == flip_frame && lb_idx[d] == flip_idx) lb_v = lb_v ^ flip_mask;
        if (d == 0 && lb_frame[d] == trunc_frame && lb_idx[d] == lb_total[d] - 1) lb_keep = 1'b0;
        rxd[d]   = lb_keep ? lb_v : '0;
        rx_dv[d] = lb_keep;
        lb_idx[d]++;
      end else begin
        if (lb_idx[d] != 0) lb_frame[d]++;
        lb_idx[d] = 0;
        rxd[d]    = '0;
        rx_dv[d]  = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: LFSR defined by its polynomial exponents, bytes computed from the frame offset.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    int   exps [4] = '{8, 6, 5, 4};
    logic fb = 1'b0;
    foreach (exps[k]) fb ^= s[exps[k]-1];
    return {s[6:0], fb};
  endfunction

  function automatic logic [7:0] model_byte(input int md, input int sd, input int k);
    logic [7:0] s;
    case (md & 3)
      1: return 8'(sd);
      2: begin
        s = (8'(sd) == 8'h00) ? 8'h01 : 8'(sd);
        repeat (k) s = lfsr_step(s);
        return s;
      end
      default: return 8'(sd + k);
    endcase
  endfunction

  task automatic run_burst(input int d, input int num, input int len, input int ipg,
                           input int md, input int sd, input int extra_at, input int exp_err);
    step_t q[$];
    int    len_eff = (len == 0) ? 1 : len;
    int    ipg_eff = (ipg == 0) ? 1 : ipg;
    for (int f = 0; f < num; f++) begin
      if (d == 1) begin
        repeat (7) q.push_back('{1'b1, 8'h55, 1'b0, 1'b1});
        q.push_back('{1'b1, 8'hD5, 1'b0, 1'b1});
      end
      for (int k = 0; k < len_eff; k++) q.push_back('{1'b1, model_byte(md, sd, k), 1'b0, 1'b1});
      repeat (ipg_eff) q.push_back('{1'b0, 8'h00, 1'b0, 1'b1});
    end
    q.push_back('{1'b0, 8'h00, 1'b1, 1'b1});
    q.push_back('{1'b0, 8'h00, 1'b0, 1'b0});

    num_frames  = CNT_W'(num);
    frame_len   = LEN_W'(len);
    ipg_len     = 8'(ipg);
    mode        = 2'(md);
    seed        = 8'(sd);
    lb_total[d] = len_eff + ((d == 1) ? 8 : 0);
    burst_id++;
    start[d] = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clock);
      start[d] = (i == extra_at);
      if (i == extra_at) begin
        num_frames = CNT_W'(num + 5);
        frame_len  = LEN_W'(len + 3);
        seed       = ~8'(sd);
      end
      check($sformatf("d%0d b%0d s%0d TX_EN", d, burst_id, i), 32'(tx_en[d]), 32'(q[i].en));
      check($sformatf("d%0d b%0d s%0d TXD", d, burst_id, i), 32'(txd[d]), 32'(q[i].d));
      check($sformatf("d%0d b%0d s%0d done", d, burst_id, i), 32'(done[d]), 32'(q[i].dn));
      check($sformatf("d%0d b%0d s%0d busy", d, burst_id, i), 32'(busy[d]), 32'(q[i].bz));
    end
    start[d] = 1'b0;
    repeat (3) @(negedge clock);
    check($sformatf("d%0d b%0d tx_frames", d, burst_id), 32'(tx_frames[d]), 32'(num));
    check($sformatf("d%0d b%0d rx_frames", d, burst_id), 32'(rx_frames[d]), 32'(num));
    check($sformatf("d%0d b%0d rx_errors", d, burst_id), 32'(rx_errors[d]), 32'(exp_err));
  endtask

  initial begin
    reset      = 1'b0;
    start      = '{1'b0, 1'b0};
    num_frames = '0;
    frame_len  = '0;
    ipg_len    = '0;
    mode       = '0;
    seed       = '0;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset d%0d TX_EN", d), 32'(tx_en[d]), 32'd0);
      check($sformatf("reset d%0d TXD", d), 32'(txd[d]), 32'd0);
      check($sformatf("reset d%0d busy", d), 32'(busy[d]), 32'd0);
      check($sformatf("reset d%0d done", d), 32'(done[d]), 32'd0);
      check($sformatf("reset d%0d counters", d),
            32'(tx_frames[d]) | 32'(rx_frames[d]) | 32'(rx_errors[d]), 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);

    // Single frame, no preamble, incrementing from 01.
    run_burst(0, 1, 9, 12, 0, 8'h01, -1, 0);
    // Three LFSR frames looped back cleanly.
    run_burst(0, 3, 64, 12, 2, 8'hA5, -1, 0);
    // Bit flip inside frame 2 payload.
    flip_frame = 1;
    flip_idx   = 10;
    run_burst(0, 3, 64, 12, 2, 8'hA5, -1, 1);
    // Same flip plus frame 3 short by one byte.
    trunc_frame = 2;
    run_burst(0, 3, 64, 12, 2, 8'hA5, -1, 2);
    flip_frame  = -1;
    trunc_frame = -1;
    // Preamble instance, constant pattern.
    run_burst(1, 1, 4, 3, 1, 8'h3C, -1, 0);
    // Boundaries: zero length, zero IPG, LFSR zero seed, reserved mode.
    run_burst(1, 2, 0, 0, 2, 8'h00, -1, 0);
    run_burst(0, 2, 5, 0, 3, 8'hFE, -1, 0);
    // Zero frames, then a start while busy that must be ignored.
    run_burst(0, 0, 7, 3, 0, 8'h11, -1, 0);
    run_burst(1, 2, 6, 2, 0, 8'h40, 3, 0);
    // Randomized bursts.
    for (int r = 0; r < 6; r++) begin
      run_burst($urandom_range(0, 1), $urandom_range(1, 3), $urandom_range(0, 12),
                $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 255), -1, 0);
    end

    // Reset in the middle of frame 2's payload.
    num_frames  = 2;
    frame_len   = 8;
    ipg_len     = 2;
    mode        = 0;
    seed        = 8'h10;
    lb_total[0] = 8;
    burst_id++;
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    repeat (12) @(negedge clock);
    check("midreset pre TX_EN", 32'(tx_en[0]), 32'd1);
    check("midreset pre tx_frames", 32'(tx_frames[0]), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("midreset TX_EN", 32'(tx_en[0]), 32'd0);
    check("midreset TXD", 32'(txd[0]), 32'd0);
    check("midreset busy", 32'(busy[0]), 32'd0);
    check("midreset tx_frames", 32'(tx_frames[0]), 32'd0);
    check("midreset rx_frames", 32'(rx_frames[0]), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    run_burst(0, 2, 10, 3, 2, 8'h5A, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
